// File: rtl/psum_accum.sv
`timescale 1ns/1ps
// psum_accum
// Drains psum vectors from the output FIFO and accumulates them across n_kij
// kernel positions into an n_out x col bank of saturating signed sums. The
// finished sums are read through a registered, ReLU-capable port.
//
// Ports:
//   clk      - single clock, all state on the rising edge
//   reset    - synchronous, active-high
//   start    - one-cycle pulse, begins an accumulation pass (ignored while busy)
//   i_valid  - FIFO has a head vector
//   i_data   - head vector, lane i at bits [psum_bw*(i+1)-1 : psum_bw*i]
//   o_rd     - pop request to the FIFO (combinational)
//   o_busy   - pass in progress
//   o_done   - pass complete, bank readable
//   relu_en  - clamp negative lanes to zero on readout
//   rd_addr  - readout vector index
//   rd_en    - readout strobe, o_data updates on the next edge
//   o_data   - readout vector
// n_out must be at least 2.
module psum_accum #(
    parameter int unsigned col     = 8,
    parameter int unsigned psum_bw = 16,
    parameter int unsigned n_out   = 16,
    parameter int unsigned n_kij   = 9
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       i_valid,
    input  logic [psum_bw*col-1:0]     i_data,
    output logic                       o_rd,
    output logic                       o_busy,
    output logic                       o_done,
    input  logic                       relu_en,
    input  logic [$clog2(n_out)-1:0]   rd_addr,
    input  logic                       rd_en,
    output logic [psum_bw*col-1:0]     o_data
);

    localparam int unsigned AW = $clog2(n_out);
    localparam int unsigned KW = (n_kij > 1) ? $clog2(n_kij) : 1;
    localparam int unsigned VW = psum_bw * col;

    typedef enum logic [1:0] {StIdle, StAcc, StDone} state_e;

    state_e                    r_state;
    logic [AW-1:0]             r_addr;
    logic [KW-1:0]             r_kij;
    logic [n_out-1:0][VW-1:0]  r_acc;

    logic [VW-1:0]             w_acc_next;
    logic [VW-1:0]             w_rd_vec;
    logic                      w_accept;
    logic                      w_addr_wrap;
    logic                      w_kij_last;
    logic                      w_rd_in_range;

    // Signed add at psum_bw+1 bits; disagreement of the top two bits means
    // the true sum left the psum_bw range, so clamp toward the sign of the sum.
    function automatic logic [psum_bw-1:0] sat_add(input logic [psum_bw-1:0] a,
                                                   input logic [psum_bw-1:0] b);
        logic [psum_bw:0] s;
        s = {a[psum_bw-1], a} + {b[psum_bw-1], b};
        if (s[psum_bw] != s[psum_bw-1]) begin
            sat_add = s[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}};
        end else begin
            sat_add = s[psum_bw-1:0];
        end
    endfunction

    assign w_accept      = (r_state == StAcc) && i_valid;
    assign w_addr_wrap   = (r_addr == AW'(n_out - 1));
    assign w_kij_last    = (r_kij == KW'(n_kij - 1));
    assign w_rd_in_range = ({1'b0, rd_addr} < (AW + 1)'(n_out));

    assign o_rd   = w_accept;
    assign o_busy = (r_state == StAcc);
    assign o_done = (r_state == StDone);

    always_comb begin
        w_acc_next = '0;
        w_rd_vec   = '0;
        for (int unsigned i = 0; i < col; i++) begin
            // The kij==0 sweep overwrites, so a new pass needs no clear.
            if (r_kij == '0) begin
                w_acc_next[i*psum_bw +: psum_bw] = i_data[i*psum_bw +: psum_bw];
            end else begin
                w_acc_next[i*psum_bw +: psum_bw] =
                    sat_add(r_acc[r_addr][i*psum_bw +: psum_bw], i_data[i*psum_bw +: psum_bw]);
            end
            if (w_rd_in_range) begin
                w_rd_vec[i*psum_bw +: psum_bw] = r_acc[rd_addr][i*psum_bw +: psum_bw];
                if (relu_en && r_acc[rd_addr][i*psum_bw + psum_bw - 1]) begin
                    w_rd_vec[i*psum_bw +: psum_bw] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
            r_addr  <= '0;
            r_kij   <= '0;
            r_acc   <= '0;
            o_data  <= '0;
        end else begin
            // Reads see the pre-update bank, even for the address being written.
            if (rd_en) begin
                o_data <= w_rd_vec;
            end
            case (r_state)
                StIdle, StDone: begin
                    if (start) begin
                        r_state <= StAcc;
                        r_addr  <= '0;
                        r_kij   <= '0;
                    end
                end
                StAcc: begin
                    if (w_accept) begin
                        r_acc[r_addr] <= w_acc_next;
                        if (w_addr_wrap) begin
                            r_addr <= '0;
                            r_kij  <= w_kij_last ? '0 : r_kij + 1'b1;
                            if (w_kij_last) begin
                                r_state <= StDone;
                            end
                        end else begin
                            r_addr <= r_addr + 1'b1;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_psum_accum.sv
`timescale 1ns/1ps
// Self-checking bench for psum_accum: a behavioural model of the bank is
// updated at each clock edge from the bench's own stimulus; readout
// expectations are queued when a read is issued and compared when o_data updates.
module tb_psum_accum;

    localparam int COL  = 8;
    localparam int BW   = 16;
    localparam int NOUT = 16;
    localparam int NKIJ = 9;
    localparam int VW   = COL * BW;
    localparam int NVEC = NOUT * NKIJ;

    logic          clk = 1'b0;
    logic          reset, start, i_valid, relu_en, rd_en;
    logic [VW-1:0] i_data;
    logic [3:0]    rd_addr;
    logic          o_rd, o_busy, o_done;
    logic [VW-1:0] o_data;

    always #5 clk = ~clk;

    psum_accum #(
        .col     (COL),
        .psum_bw (BW),
        .n_out   (NOUT),
        .n_kij   (NKIJ)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .i_valid (i_valid),
        .i_data  (i_data),
        .o_rd    (o_rd),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .relu_en (relu_en),
        .rd_addr (rd_addr),
        .rd_en   (rd_en),
        .o_data  (o_data)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [VW-1:0] exp_q[$];

    // Model state: 0 idle, 1 acc, 2 done.
    int m_acc[NOUT][COL];
    int m_state, m_addr, m_kij;
    int vec_idx, n_acc, n_pop;

    function automatic int sat16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic logic [VW-1:0] model_read(input int a, input bit relu);
        logic [VW-1:0] r;
        int v;
        r = '0;
        for (int l = 0; l < COL; l++) begin
            v = m_acc[a][l];
            if (relu && v < 0) v = 0;
            r[l*BW +: BW] = BW'(v);
        end
        return r;
    endfunction

    function automatic logic [VW-1:0] vec_for(input int mode, input int idx);
        logic [VW-1:0] r;
        int kij, addr, v;
        kij  = idx / NOUT;
        addr = idx % NOUT;
        r    = '0;
        for (int l = 0; l < COL; l++) begin
            case (mode)
                0: v = kij + 1;
                1: begin
                    if (l == 0)      v = (kij < 2) ? 30000 : 0;
                    else if (l == 1) v = (kij < 2) ? -30000 : 0;
                    else             v = (kij - 4) * (l + addr);
                end
                2: v = 1;
                default: v = -1;
            endcase
            r[l*BW +: BW] = BW'(v);
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int a = 0; a < NOUT; a++)
            for (int l = 0; l < COL; l++) m_acc[a][l] = 0;
        m_state = 0;
        m_addr  = 0;
        m_kij   = 0;
    endtask

    task automatic model_step();
        int v;
        if (reset) begin
            model_reset();
        end else if (m_state != 1) begin
            if (start) begin
                m_state = 1;
                m_addr  = 0;
                m_kij   = 0;
            end
        end else if (i_valid) begin
            for (int l = 0; l < COL; l++) begin
                v = int'($signed(i_data[l*BW +: BW]));
                m_acc[m_addr][l] = (m_kij == 0) ? v : sat16(m_acc[m_addr][l] + v);
            end
            vec_idx++;
            n_acc++;
            if (m_addr == NOUT - 1 && m_kij == NKIJ - 1) m_state = 2;
            if (m_addr == NOUT - 1) begin
                m_addr = 0;
                m_kij  = (m_kij == NKIJ - 1) ? 0 : m_kij + 1;
            end else begin
                m_addr++;
            end
        end
    endtask

    // One clock cycle: sample handshake/status mid-cycle, then advance the model.
    task automatic tick(output logic [2:0] obs, output logic [2:0] ex);
        @(negedge clk);
        obs = {o_rd, o_busy, o_done};
        ex  = {(m_state == 1) && i_valid, m_state == 1, m_state == 2};
        if (o_rd === 1'b1) n_pop++;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic start_pass(input string name);
        logic [2:0] obs, ex;
        vec_idx = 0;
        n_acc   = 0;
        n_pop   = 0;
        start   = 1'b1;
        i_valid = 1'b0;
        tick(obs, ex);
        start = 1'b0;
        n_cmp++;
        if (obs !== ex) begin
            n_err++;
            $display("FAIL %s_start: {rd,busy,done} got %b want %b", name, obs, ex);
        end
    endtask

    // Streams vectors until stop_at acceptances; optionally reads address 3 in
    // the same cycle as its kij==0 write.
    task automatic run_stream(input int mode, input bit bubbles, input int stop_at,
                              input bit probe3, input string name);
        logic [2:0]    obs, ex;
        logic [VW-1:0] got, e;
        int  budget;
        bit  pend, probed;
        budget = 0;
        pend   = 0;
        probed = 0;
        while (n_acc < stop_at && budget < 3000) begin
            i_valid = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
            i_data  = vec_for(mode, vec_idx);
            if (probe3 && !probed && m_state == 1 && m_addr == 3 && m_kij == 0 && i_valid) begin
                rd_en   = 1'b1;
                rd_addr = 4'd3;
                relu_en = 1'b0;
                exp_q.push_back(model_read(3, 1'b0));
                probed  = 1;
                pend    = 1;
            end
            tick(obs, ex);
            budget++;
            n_cmp++;
            if (obs !== ex) begin
                n_err++;
                $display("FAIL %s_hs cyc=%0d: {rd,busy,done} got %b want %b", name, budget, obs, ex);
            end
            if (pend) begin
                rd_en = 1'b0;
                pend  = 0;
                got   = o_data;
                e     = exp_q.pop_front();
                n_cmp++;
                if (got !== e) begin
                    n_err++;
                    $display("FAIL %s_rd_during_write: got %h want %h", name, got, e);
                end
            end
        end
        if (n_acc < stop_at) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: accepted %0d want %0d", name, n_acc, stop_at);
        end
    endtask

    task automatic test_reset();
        logic [2:0]    obs, ex;
        logic [VW-1:0] got, e;
        reset   = 1'b1;
        start   = 1'b0;
        i_valid = 1'b0;
        i_data  = '0;
        rd_en   = 1'b0;
        rd_addr = '0;
        relu_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        reset = 1'b0;
        n_cmp++;
        if (o_data !== '0) begin
            n_err++;
            $display("FAIL reset_odata: got %h want 0", o_data);
        end
        i_valid = 1'b1;
        i_data  = vec_for(0, 0);
        repeat (5) begin
            tick(obs, ex);
            n_cmp++;
            if (obs !== ex) begin
                n_err++;
                $display("FAIL idle_hs: {rd,busy,done} got %b want %b", obs, ex);
            end
        end
        i_valid = 1'b0;
        for (int a = 0; a < NOUT; a += 5) begin
            rd_en   = 1'b1;
            rd_addr = 4'(a);
            exp_q.push_back(model_read(a, 1'b0));
            tick(obs, ex);
            rd_en = 1'b0;
            got   = o_data;
            e     = exp_q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_err++;
                $display("FAIL idle_read a=%0d: got %h want %h", a, got, e);
            end
        end
    endtask

    task automatic test_full_pass();
        logic [2:0]    obs, ex;
        logic [VW-1:0] got, e;
        start_pass("full");
        run_stream(0, 1'b0, NVEC, 1'b0, "full");
        i_valid = 1'b1;
        repeat (3) begin
            tick(obs, ex);
            n_cmp++;
            if (obs !== ex) begin
                n_err++;
                $display("FAIL full_post_done: {rd,busy,done} got %b want %b", obs, ex);
            end
        end
        i_valid = 1'b0;
        for (int a = 0; a < NOUT; a++) begin
            rd_en   = 1'b1;
            rd_addr = 4'(a);
            relu_en = 1'b0;
            exp_q.push_back(model_read(a, 1'b0));
            tick(obs, ex);
            rd_en = 1'b0;
            got   = o_data;
            e     = exp_q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_err++;
                $display("FAIL full_read a=%0d: got %h want %h", a, got, e);
            end
        end
    endtask

    task automatic test_bubbles();
        logic [2:0]    obs, ex;
        logic [VW-1:0] got, e;
        start_pass("bub");
        run_stream(0, 1'b1, NVEC, 1'b0, "bub");
        i_valid = 1'b0;
        n_cmp++;
        if (n_pop !== NVEC) begin
            n_err++;
            $display("FAIL bub_pop_count: got %0d want %0d", n_pop, NVEC);
        end
        for (int a = 0; a < NOUT; a++) begin
            rd_en   = 1'b1;
            rd_addr = 4'(a);
            exp_q.push_back(model_read(a, 1'b0));
            tick(obs, ex);
            rd_en = 1'b0;
            got   = o_data;
            e     = exp_q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_err++;
                $display("FAIL bub_read a=%0d: got %h want %h", a, got, e);
            end
        end
    endtask

    task automatic test_sat_relu();
        logic [2:0]    obs, ex;
        logic [VW-1:0] got, e;
        start_pass("sat");
        run_stream(1, 1'b0, NVEC, 1'b0, "sat");
        i_valid = 1'b0;
        for (int r = 0; r < 2; r++) begin
            for (int a = 0; a < NOUT; a++) begin
                rd_en   = 1'b1;
                rd_addr = 4'(a);
                relu_en = 1'(r);
                exp_q.push_back(model_read(a, 1'(r)));
                tick(obs, ex);
                rd_en = 1'b0;
                got   = o_data;
                e     = exp_q.pop_front();
                n_cmp++;
                if (got !== e) begin
                    n_err++;
                    $display("FAIL sat_read relu=%0d a=%0d: got %h want %h", r, a, got, e);
                end
                if (r == 0 && a == 5) begin
                    n_cmp++;
                    if (got[15:0] !== 16'h7fff || got[31:16] !== 16'h8000) begin
                        n_err++;
                        $display("FAIL sat_clamp: lanes1:0 got %h want 80007fff", got[31:0]);
                    end
                end
            end
        end
        relu_en = 1'b0;
    endtask

    task automatic test_reset_midpass();
        logic [2:0]    obs, ex;
        logic [VW-1:0] got, e;
        start_pass("mid");
        run_stream(2, 1'b0, 50, 1'b0, "mid");
        // In-progress readout during ACC.
        i_valid = 1'b0;
        rd_en   = 1'b1;
        rd_addr = 4'd0;
        exp_q.push_back(model_read(0, 1'b0));
        tick(obs, ex);
        rd_en = 1'b0;
        got   = o_data;
        e     = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin
            n_err++;
            $display("FAIL mid_partial_read: got %h want %h", got, e);
        end
        reset   = 1'b1;
        start   = 1'b1;
        i_valid = 1'b1;
        tick(obs, ex);
        reset = 1'b0;
        start = 1'b0;
        n_cmp++;
        if (o_busy !== 1'b0 || o_rd !== 1'b0 || o_data !== '0) begin
            n_err++;
            $display("FAIL mid_after_reset: busy %b rd %b data %h want 0 0 0", o_busy, o_rd, o_data);
        end
        tick(obs, ex);
        n_cmp++;
        if (obs !== ex) begin
            n_err++;
            $display("FAIL mid_idle_hs: {rd,busy,done} got %b want %b", obs, ex);
        end
        i_valid = 1'b0;
        for (int a = 0; a < NOUT; a += 3) begin
            rd_en   = 1'b1;
            rd_addr = 4'(a);
            exp_q.push_back(model_read(a, 1'b0));
            tick(obs, ex);
            rd_en = 1'b0;
            got   = o_data;
            e     = exp_q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_err++;
                $display("FAIL mid_zero_read a=%0d: got %h want %h", a, got, e);
            end
        end
        start_pass("mid2");
        run_stream(2, 1'b0, NVEC, 1'b0, "mid2");
        i_valid = 1'b0;
        for (int a = 0; a < NOUT; a++) begin
            rd_en   = 1'b1;
            rd_addr = 4'(a);
            exp_q.push_back(model_read(a, 1'b0));
            tick(obs, ex);
            rd_en = 1'b0;
            got   = o_data;
            e     = exp_q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_err++;
                $display("FAIL mid2_read a=%0d: got %h want %h", a, got, e);
            end
        end
    endtask

    task automatic test_restart();
        logic [2:0]    obs, ex;
        logic [VW-1:0] got, e;
        start_pass("rst");
        run_stream(3, 1'b0, NVEC, 1'b1, "rst");
        i_valid = 1'b0;
        for (int r = 0; r < 2; r++) begin
            for (int a = 0; a < NOUT; a++) begin
                rd_en   = 1'b1;
                rd_addr = 4'(a);
                relu_en = 1'(r);
                exp_q.push_back(model_read(a, 1'(r)));
                tick(obs, ex);
                rd_en = 1'b0;
                got   = o_data;
                e     = exp_q.pop_front();
                n_cmp++;
                if (got !== e) begin
                    n_err++;
                    $display("FAIL rst_read relu=%0d a=%0d: got %h want %h", r, a, got, e);
                end
            end
        end
        relu_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_pass();
        test_bubbles();
        test_sat_relu();
        test_reset_midpass();
        test_restart();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/psum_accum.md
# psum_accum

Downstream consumer of the output FIFO: drains psum vectors (one `psum_bw`-wide lane per array column) whenever the FIFO reports a vector ready. Accumulates them across `n_kij` kernel positions into an `n_out` x `col` accumulator bank. Exposes the finished sums through a registered, ReLU-capable read port. Sits between the output FIFO and the output SRAM write-back path.

## Interface
Parameters:
- `col`, 8, number of lanes per vector (array columns)
- `psum_bw`, 16, signed lane width, in and out
- `n_out`, 16, output pixels (vectors) per kernel position
- `n_kij`, 9, kernel positions accumulated per output

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  one-cycle pulse, begins an accumulation pass
- `i_valid`  in  1  FIFO has a head vector (FIFO `o_valid`)
- `i_data`  in  `psum_bw*col`  head vector; lane i = bits [psum_bw*(i+1)-1 : psum_bw*i]
- `o_rd`  out  1  pop request to FIFO `rd`
- `o_busy`  out  1  pass in progress
- `o_done`  out  1  pass complete, bank readable
- `relu_en`  in  1  clamp negative lanes to 0 on readout
- `rd_addr`  in  `$clog2(n_out)`  readout vector index
- `rd_en`  in  1  readout strobe
- `o_data`  out  `psum_bw*col`  readout vector

## Operation
- FSM states: IDLE, ACC, DONE.
  - IDLE -> ACC on `start`.
  - ACC -> DONE on acceptance of vector `n_out*n_kij - 1`.
  - DONE -> ACC on `start`.
  - `start` is ignored in ACC.
- Counters:
  - `addr` counts 0..`n_out`-1 and wraps.
  - `kij` counts 0..`n_kij`-1 and increments when `addr` wraps.
  - Both counters clear on entry to ACC.
- Handshake:
  - `o_rd` = (state==ACC) & `i_valid`, combinational.
  - `i_data` is the head vector, valid while `i_valid` is high.
  - A vector is accepted on any rising edge with `o_rd`=1.
  - No acceptance occurs in IDLE or DONE, even with `i_valid` high.
- Accumulate, per lane, on acceptance:
  - If `kij`==0, `acc[addr][lane]` <= `i_data` lane (overwrite, so no clear pass is needed).
  - Otherwise `acc[addr][lane]` <= sat(`acc[addr][lane]` + lane).
  - Addition is signed two's complement at `psum_bw`+1 bits.
  - Saturation clamps to [-2^(psum_bw-1), 2^(psum_bw-1)-1].
- Readout:
  - When `rd_en`=1, `o_data` <= `acc[rd_addr]`, lane-wise passed through ReLU if `relu_en` (negative -> 0).
  - Otherwise `o_data` holds its value.
  - Readout is legal in any state. In ACC it returns in-progress sums.
  - `rd_addr` >= `n_out` returns 0.
- Status: `o_busy` = (state==ACC). `o_done` = (state==DONE).

## Timing
- Reset values:
  - state = IDLE, `addr` = 0, `kij` = 0, all acc entries = 0.
  - `o_data` = 0, `o_rd` = 0, `o_busy` = 0, `o_done` = 0.
- `start` at edge N: `o_busy` = 1 from cycle N+1. `o_rd` can first be 1 in cycle N+1.
- Throughput is one vector per cycle while `i_valid` stays high. Gaps in `i_valid` stall the counters with no other effect.
- Final acceptance at edge M: `o_done` = 1 and `o_busy` = 0 from cycle M+1. `o_rd` = 0 in cycle M+1 even if `i_valid` = 1.
- Readout latency is 1 cycle: `rd_en` sampled at edge R, `o_data` is valid after R.
- Simultaneous acceptance to address A and readout of A returns the pre-update value.
- Reset asserted mid-ACC:
  - Next edge returns to IDLE and zeroes counters, acc and `o_data`.
  - `o_rd` drops combinationally with the state.
  - `start` in the same cycle as `reset` is ignored.
- `start` while in DONE begins a new pass. Old sums are overwritten by the `kij`=0 sweep.

## Test plan
- Reset then idle: hold `i_valid`=1 for 5 cycles with no `start` -> `o_rd` stays 0, `o_busy`/`o_done` = 0, readout of any address = 0.
- Full pass, `n_out`=16, `n_kij`=9: `start`, then stream 144 vectors with every lane of the kij-th sweep = kij+1 and `i_valid` continuous.
  - `o_done` rises exactly 1 cycle after vector 144 is accepted.
  - Every lane of every address = 45.
  - `o_rd` = 0 after completion.
- Bubbles: same stream with `i_valid` toggled pseudo-randomly (about 50%) -> identical sums of 45; accepted-vector count = 144; no pop while `i_valid`=0.
- Saturation/ReLU: lane 0 fed 30000 for kij 0 and 1 -> reads 32767. Lane 1 fed -30000 twice -> reads -32768 with `relu_en`=0 and 0 with `relu_en`=1.
- Reset mid-pass: assert `reset` after 50 acceptances.
  - Next cycle: `o_busy`=0, all reads = 0.
  - A fresh `start` and 144 vectors of value 1 -> all lanes = 9.
- Re-start from DONE: a second pass with lanes = -1 overwrites the first -> all lanes = -9 (0 with `relu_en`). Readout of address 3 during a same-cycle write to address 3 returns the old value.
